updown_counter_mod: RTL
=======================

Name: updown_counter_mod

Overview:
Parametrised up/down counter with programmable terminal value (modulus), programmable step, and wrap or saturate mode.
Produces sticky overflow/underflow flags and a one-cycle wrap pulse.
It is the next-generation replacement for the fixed-width load/enable/up-down counter and keeps its load_n/ce/up_down/data_load control set.
Sits as a general timing/event counter driven by control FSMs; a counter_if-style interface and monitor observe it.

Parameters:
WIDTH, 8, counter, data_load and limit width in bits
STEP_W, 4, step input width; must satisfy STEP_W <= WIDTH
PRESCALE, 4, ce division ratio (>=1); used only with COUNTER_PRESCALE_EN

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
load_n  input  1  active-low synchronous load
data_load  input  WIDTH  load value
ce  input  1  count enable
up_down  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment/decrement amount (unsigned)
limit  input  WIDTH  terminal value; count range is 0..limit
sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo (limit+1)
clr_flags  input  1  clears sticky flags
count_out  output  WIDTH  registered count
max_count  output  1  count_out == limit (combinational decode of register)
zero  output  1  count_out == 0 (combinational decode of register)
wrap_pulse  output  1  registered; high for one cycle after any bound crossing
ovf_sticky  output  1  registered sticky overflow
unf_sticky  output  1  registered sticky underflow

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. No asynchronous logic.
- Reset values: count_out=0, wrap_pulse=0, ovf_sticky=0, unf_sticky=0; therefore zero=1, and max_count=(limit==0).
- Priority per edge: rst > load (load_n==0) > ce. Latency is 1 cycle from any input to count_out.
- Load: count_out <= min(data_load, limit). No flags are set and wrap_pulse=0. Load overrides ce.
- Hold: if ce=0 or step=0, count_out holds, wrap_pulse=0, and no flag changes.
- Up (ce=1, up_down=1): sum = count_out + step, computed in WIDTH+1 bits.
  - sum <= limit: count_out <= sum.
  - sum > limit, wrap mode: count_out <= sum - (limit+1). If that result is still > limit (step > limit+1, a configuration error), count_out <= limit.
  - sum > limit, saturate mode: count_out <= limit.
  - In both overflow cases, set ovf_sticky and assert wrap_pulse.
- Down (ce=1, up_down=0):
  - count_out >= step: count_out <= count_out - step.
  - Otherwise, wrap mode: count_out <= count_out + (limit+1) - step, in WIDTH+1 bits, clamped to limit.
  - Otherwise, saturate mode: count_out <= 0.
  - In both underflow cases, set unf_sticky and assert wrap_pulse.
- Saturate holding at a bound still counts as a crossing each enabled cycle: at limit, counting up with step>0 re-asserts wrap_pulse and ovf.
- limit lowered below count_out, then a ce cycle:
  - Up: counts as overflow; count_out <= 0 (wrap) or limit (saturate).
  - Down: normal subtraction, result clamped to limit.
- wrap_pulse is registered and lasts exactly one cycle per crossing. Back-to-back crossings keep it high.
- clr_flags clears both sticky flags. If a new overflow/underflow occurs in the same cycle, that flag is set (set wins).
- limit=0: count_out stays 0. Every enabled count with step>0 is a crossing.

Optional Feature:
Macro COUNTER_PRESCALE_EN.
- Defined: an internal prescale counter, range 0..PRESCALE-1, advances on each ce=1 cycle. The counting action occurs only on the cycle it equals PRESCALE-1, after which it returns to 0. rst and load clear it to 0. ce=0 freezes it.
- Not defined: no prescaler; every ce=1 cycle is a counting cycle. PRESCALE is ignored.

Test Plan:
1. Reset mid-count: count_out=0x37, ovf_sticky=1, rst=1 for one edge -> count_out=0, zero=1, ovf/unf/wrap_pulse=0.
2. Wrap up: limit=9, step=1, sat_mode=0, count_out=9, ce=1, up_down=1 -> count_out=0, wrap_pulse=1 for one cycle, ovf_sticky=1; next edge count_out=1, wrap_pulse=0.
3. Saturate up: limit=200, count_out=198, step=5, sat_mode=1 -> count_out=200, max_count=1, ovf_sticky=1; next edge count_out stays 200 and wrap_pulse=1 again.
4. Down wrap: limit=9, count_out=1, step=3, sat_mode=0, up_down=0 -> count_out=8, unf_sticky=1, wrap_pulse=1.
5. Load priority/clamp: load_n=0, ce=1, up_down=1, data_load=0xF0, limit=0x80 -> count_out=0x80, no flags set.
6. clr_flags collision: ovf_sticky=1, clr_flags=1 with an underflow in the same cycle -> ovf_sticky=0, unf_sticky=1; with COUNTER_PRESCALE_EN and PRESCALE=4, ce held high -> count advances every 4th cycle.

Source files
------------

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, step, wrap/saturate mode and flags.
// Optional ce prescaler enabled by defining COUNTER_PRESCALE_EN.
module updown_counter_mod #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_n,
  input  logic [WIDTH-1:0]  data_load,
  input  logic              ce,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count_out,
  output logic              max_count,
  output logic              zero,
  output logic              wrap_pulse,
  output logic              ovf_sticky,
  output logic              unf_sticky
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;
  logic             r_unf;
  logic             w_tick;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] r_pre;
  logic          w_pre_last;

  assign w_pre_last = (r_pre == PW'(PRESCALE - 1));
  assign w_tick     = ce & w_pre_last;

  always_ff @(posedge clk) begin
    if (rst || !load_n) begin
      r_pre <= '0;
    end else if (ce) begin
      r_pre <= w_pre_last ? '0 : r_pre + 1'b1;
    end
  end
`else
  logic w_unused_pre;
  assign w_unused_pre = PRESCALE[0];
  assign w_tick       = ce;
`endif

  // All arithmetic is one bit wider so carries/borrows stay visible.
  logic [WIDTH:0]   w_cnt_x;
  logic [WIDTH:0]   w_lim_x;
  logic [WIDTH:0]   w_step_x;
  logic [WIDTH:0]   w_lim1;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_up_wrap;
  logic [WIDTH:0]   w_dn_sub;
  logic [WIDTH:0]   w_dn_wrap;
  logic [WIDTH-1:0] w_ld;
  logic [WIDTH-1:0] w_next;
  logic             w_ovf;
  logic             w_unf;

  assign w_cnt_x   = {1'b0, r_count};
  assign w_lim_x   = {1'b0, limit};
  assign w_step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign w_lim1    = w_lim_x + 1'b1;
  assign w_sum     = w_cnt_x + w_step_x;
  assign w_up_wrap = w_sum - w_lim1;
  assign w_dn_sub  = w_cnt_x - w_step_x;
  assign w_dn_wrap = w_cnt_x + w_lim1 - w_step_x;
  assign w_ld      = (data_load > limit) ? limit : data_load;

  always_comb begin
    w_next = r_count;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    if (w_tick && (step != '0)) begin
      unique case (1'b1)
        up_down: begin
          if (w_sum > w_lim_x) begin
            w_ovf = 1'b1;
            if (sat_mode)
              w_next = limit;
            else if (w_cnt_x > w_lim_x)
              w_next = '0;
            else if (w_up_wrap > w_lim_x)
              w_next = limit;
            else
              w_next = w_up_wrap[WIDTH-1:0];
          end else begin
            w_next = w_sum[WIDTH-1:0];
          end
        end
        !up_down: begin
          if (w_cnt_x >= w_step_x) begin
            if (w_dn_sub > w_lim_x)
              w_next = limit;
            else
              w_next = w_dn_sub[WIDTH-1:0];
          end else begin
            w_unf = 1'b1;
            if (sat_mode)
              w_next = '0;
            else if (w_dn_wrap > w_lim_x)
              w_next = limit;
            else
              w_next = w_dn_wrap[WIDTH-1:0];
          end
        end
        default: w_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!load_n) begin
      r_count <= w_ld;
      r_wrap  <= 1'b0;
      r_ovf   <= r_ovf & ~clr_flags;
      r_unf   <= r_unf & ~clr_flags;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_ovf | w_unf;
      r_ovf   <= (r_ovf & ~clr_flags) | w_ovf;
      r_unf   <= (r_unf & ~clr_flags) | w_unf;
    end
  end

  assign count_out  = r_count;
  assign max_count  = (r_count == limit);
  assign zero       = (r_count == '0);
  assign wrap_pulse = r_wrap;
  assign ovf_sticky = r_ovf;
  assign unf_sticky = r_unf;

endmodule
